// File: rtl/auto_contrast_coeff.sv
// auto_contrast_coeff: per-frame min/max statistics and Q8.8 gain/offset that stretch [min,max] to [0,255].
// Ports: clk/rst_n (async active-low); data_valid_i qualifies pixel_in_i, sof_i, eof_i;
// alpha_out_o (Q8.8 unsigned) and beta_out_o (signed) update with the coeff_valid_o pulse;
// busy_o is high while computing; frame_min_o/frame_max_o hold the last completed frame's
// statistics; frame_dropped_o pulses when a sof arrives while busy.
module auto_contrast_coeff #(
   parameter int DATA_WIDTH  = 8,
   parameter int COEFF_WIDTH = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   data_valid_i,
   input  logic [DATA_WIDTH-1:0]  pixel_in_i,
   input  logic                   sof_i,
   input  logic                   eof_i,
   output logic [COEFF_WIDTH-1:0] alpha_out_o,
   output logic [COEFF_WIDTH-1:0] beta_out_o,
   output logic                   coeff_valid_o,
   output logic                   busy_o,
   output logic [DATA_WIDTH-1:0]  frame_min_o,
   output logic [DATA_WIDTH-1:0]  frame_max_o,
   output logic                   frame_dropped_o
);
   typedef enum logic [2:0] {IDLE, ACCUM, SETUP, DIV, SCALE, OUT} state_e;
   state_e state_q, state_d;
   logic [DATA_WIDTH-1:0]  run_min_q, run_max_q, fmin_q, fmax_q, range_q;
   logic [8:0]             rem_q, rem_sh, rem_nx;
   logic [15:0]            quo_q, p8, beta_sat;
   logic [3:0]             cnt_q;
   logic [COEFF_WIDTH-1:0] alpha_c_q, beta_c_q, alpha_q, beta_q;
   logic [23:0]            prod;
   logic                   cv_q, drop_q, busy, ge, zero;
   assign busy = (state_q == SETUP) || (state_q == DIV) || (state_q == SCALE) || (state_q == OUT);
   // Restoring divider: the numerator shifts out of quo_q MSB-first while quotient bits shift in.
   assign rem_sh   = {rem_q[7:0], quo_q[15]};
   assign ge       = rem_sh >= {1'b0, range_q};
   assign rem_nx   = ge ? rem_sh - {1'b0, range_q} : rem_sh;
   assign zero     = range_q == '0;
   assign prod     = quo_q * fmin_q;
   assign p8       = prod[23:8];
   // Offsets beyond -32768 cannot be represented, so they clamp to the most negative value.
   assign beta_sat = (p8 > 16'h8000) ? 16'h8000 : 16'h0000 - p8;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (data_valid_i && sof_i) state_d = eof_i ? SETUP : ACCUM;
         ACCUM:   if (data_valid_i && eof_i) state_d = SETUP;
         SETUP:   state_d = DIV;
         DIV:     if (cnt_q == 4'd15) state_d = SCALE;
         SCALE:   state_d = OUT;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         run_min_q <= '0;
         run_max_q <= '0;
         fmin_q    <= '0;
         fmax_q    <= '0;
         range_q   <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         cnt_q     <= '0;
         alpha_c_q <= 16'h0100;
         beta_c_q  <= '0;
         alpha_q   <= 16'h0100;
         beta_q    <= '0;
         cv_q      <= 1'b0;
         drop_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cv_q    <= state_q == OUT;
         drop_q  <= busy && data_valid_i && sof_i;
         if (!busy && data_valid_i && sof_i) begin
            run_min_q <= pixel_in_i;
            run_max_q <= pixel_in_i;
         end else if (state_q == ACCUM && data_valid_i) begin
            run_min_q <= (pixel_in_i < run_min_q) ? pixel_in_i : run_min_q;
            run_max_q <= (pixel_in_i > run_max_q) ? pixel_in_i : run_max_q;
         end
         case (state_q)
            SETUP: begin
               fmin_q  <= run_min_q;
               fmax_q  <= run_max_q;
               range_q <= run_max_q - run_min_q;
               rem_q   <= '0;
               quo_q   <= 16'hFF00;
               cnt_q   <= '0;
            end
            DIV: begin
               rem_q <= rem_nx;
               quo_q <= {quo_q[14:0], ge};
               cnt_q <= cnt_q + 4'd1;
            end
            SCALE: begin
               // A flat frame has no range to stretch; the divider still ran for fixed latency.
               alpha_c_q <= zero ? 16'h0100 : quo_q;
               beta_c_q  <= zero ? 16'h0000 : beta_sat;
            end
            OUT: begin
               alpha_q <= alpha_c_q;
               beta_q  <= beta_c_q;
            end
            default: ;
         endcase
      end
   end
   assign alpha_out_o     = alpha_q;
   assign beta_out_o      = beta_q;
   assign coeff_valid_o   = cv_q;
   assign busy_o          = busy;
   assign frame_min_o     = fmin_q;
   assign frame_max_o     = fmax_q;
   assign frame_dropped_o = drop_q;
endmodule

// File: tb/tb_auto_contrast_coeff.sv
// tb_auto_contrast_coeff: scoreboard bench for auto_contrast_coeff.
module tb_auto_contrast_coeff;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        data_valid = 1'b0, sof = 1'b0, eof = 1'b0;
   logic [7:0]  pixel_in = '0;
   logic [15:0] alpha_out, beta_out;
   logic        coeff_valid, busy, frame_dropped;
   logic [7:0]  frame_min, frame_max;
   int          errors = 0, checks = 0;
   typedef struct {logic [15:0] a; logic [15:0] b; logic [7:0] mn; logic [7:0] mx;} exp_t;
   typedef logic [7:0] pix_q_t[$];
   exp_t sb[$];
   auto_contrast_coeff dut (
      .clk(clk), .rst_n(rst_n), .data_valid_i(data_valid), .pixel_in_i(pixel_in),
      .sof_i(sof), .eof_i(eof), .alpha_out_o(alpha_out), .beta_out_o(beta_out),
      .coeff_valid_o(coeff_valid), .busy_o(busy), .frame_min_o(frame_min),
      .frame_max_o(frame_max), .frame_dropped_o(frame_dropped)
   );
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   function automatic exp_t model(input int mn, input int mx);
      exp_t e;
      int   a, p;
      e.mn = 8'(mn);
      e.mx = 8'(mx);
      if (mx == mn) begin
         e.a = 16'h0100;
         e.b = 16'h0000;
      end else begin
         a   = 65280 / (mx - mn);
         p   = (a * mn) / 256;
         e.a = 16'(a);
         e.b = (p > 32768) ? 16'h8000 : 16'(-p);
      end
      return e;
   endfunction
   task automatic send_frame(input pix_q_t px);
      int mn = 255, mx = 0;
      foreach (px[i]) begin
         data_valid = 1'b1;
         pixel_in   = px[i];
         sof        = (i == 0);
         eof        = (i == px.size() - 1);
         if (px[i] < mn) mn = px[i];
         if (px[i] > mx) mx = px[i];
         tick();
      end
      data_valid = 1'b0;
      sof        = 1'b0;
      eof        = 1'b0;
      sb.push_back(model(mn, mx));
   endtask
   task automatic wait_coeff(output int n);
      n = 0;
      while (!coeff_valid && n < 40) begin
         tick();
         n++;
      end
   endtask
   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) tick();
      checks++; if (alpha_out !== 16'h0100) begin errors++; $display("FAIL reset_alpha got %h want 0100", alpha_out); end
      checks++; if (beta_out !== 16'h0000) begin errors++; $display("FAIL reset_beta got %h want 0000", beta_out); end
      checks++; if ({coeff_valid, busy, frame_dropped} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {coeff_valid, busy, frame_dropped}); end
      checks++; if ({frame_min, frame_max} !== 16'h0000) begin errors++; $display("FAIL reset_minmax got %h want 0000", {frame_min, frame_max}); end
      rst_n = 1'b1;
      tick();
   endtask
   task automatic test_ramp();
      pix_q_t q;
      exp_t   e;
      int     n;
      for (int v = 50; v <= 200; v++) q.push_back(8'(v));
      send_frame(q);
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ramp_busy got %b want 1", busy); end
      wait_coeff(n);
      e = sb.pop_front();
      checks++; if (n !== 19) begin errors++; $display("FAIL ramp_latency got %0d want 19", n); end
      checks++; if (alpha_out !== e.a || alpha_out !== 16'h01B3) begin errors++; $display("FAIL ramp_alpha got %h want %h", alpha_out, e.a); end
      checks++; if (beta_out !== e.b || beta_out !== 16'hFFAC) begin errors++; $display("FAIL ramp_beta got %h want %h", beta_out, e.b); end
      checks++; if (frame_min !== e.mn || frame_max !== e.mx) begin errors++; $display("FAIL ramp_minmax got %0d/%0d want %0d/%0d", frame_min, frame_max, e.mn, e.mx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ramp_busy_end got %b want 0", busy); end
      tick();
      checks++; if (coeff_valid !== 1'b0) begin errors++; $display("FAIL ramp_pulse_width got %b want 0", coeff_valid); end
      checks++; if (alpha_out !== e.a || beta_out !== e.b) begin errors++; $display("FAIL ramp_hold got %h/%h want %h/%h", alpha_out, beta_out, e.a, e.b); end
   endtask
   task automatic test_frames();
      pix_q_t frames[6];
      string  names[6] = '{"full_range", "narrow", "saturate", "single", "constant", "small"};
      exp_t   e;
      int     n;
      frames[0] = '{8'd30, 8'd0, 8'd128, 8'd255, 8'd77};
      frames[1] = '{8'd100, 8'd101, 8'd100, 8'd101};
      frames[2] = '{8'd254, 8'd255, 8'd255};
      frames[3] = '{8'd77};
      frames[4] = '{8'd128, 8'd128, 8'd128, 8'd128};
      frames[5] = '{8'd10, 8'd20, 8'd30};
      for (int f = 0; f < 6; f++) begin
         send_frame(frames[f]);
         wait_coeff(n);
         e = sb.pop_front();
         checks++; if (n !== 19) begin errors++; $display("FAIL %s_latency got %0d want 19", names[f], n); end
         checks++; if (alpha_out !== e.a) begin errors++; $display("FAIL %s_alpha got %h want %h", names[f], alpha_out, e.a); end
         checks++; if (beta_out !== e.b) begin errors++; $display("FAIL %s_beta got %h want %h", names[f], beta_out, e.b); end
         checks++; if (frame_min !== e.mn || frame_max !== e.mx) begin errors++; $display("FAIL %s_minmax got %0d/%0d want %0d/%0d", names[f], frame_min, frame_max, e.mn, e.mx); end
         repeat (2) tick();
      end
   endtask
   task automatic test_dropped();
      exp_t e;
      int   n, pulses = 0;
      send_frame('{8'd60, 8'd90, 8'd75});
      repeat (5) tick();
      data_valid = 1'b1; sof = 1'b1; pixel_in = 8'd0;
      tick();
      checks++; if (frame_dropped !== 1'b1) begin errors++; $display("FAIL drop_pulse got %b want 1", frame_dropped); end
      sof = 1'b0; eof = 1'b1; pixel_in = 8'd255;
      tick();
      data_valid = 1'b0; eof = 1'b0;
      checks++; if (frame_dropped !== 1'b0) begin errors++; $display("FAIL drop_pulse_width got %b want 0", frame_dropped); end
      wait_coeff(n);
      e = sb.pop_front();
      checks++; if (n + 7 !== 19) begin errors++; $display("FAIL drop_latency got %0d want 19", n + 7); end
      checks++; if (alpha_out !== e.a || beta_out !== e.b) begin errors++; $display("FAIL drop_coeff got %h/%h want %h/%h", alpha_out, beta_out, e.a, e.b); end
      checks++; if (frame_min !== e.mn || frame_max !== e.mx) begin errors++; $display("FAIL drop_minmax got %0d/%0d want %0d/%0d", frame_min, frame_max, e.mn, e.mx); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drop_busy got %b want 0", busy); end
      repeat (25) begin tick(); if (coeff_valid) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL drop_no_extra got %0d want 0", pulses); end
   endtask
   task automatic test_invalid();
      exp_t e;
      int   n, pulses = 0, busy_seen = 0;
      data_valid = 1'b0; sof = 1'b1; eof = 1'b1; pixel_in = 8'd5;
      repeat (3) begin tick(); busy_seen += busy; end
      data_valid = 1'b1; sof = 1'b0; eof = 1'b0; pixel_in = 8'd3;
      repeat (2) begin tick(); busy_seen += busy; end
      data_valid = 1'b0;
      repeat (22) begin tick(); if (coeff_valid) pulses++; busy_seen += busy; end
      checks++; if (pulses + busy_seen !== 0) begin errors++; $display("FAIL invalid_idle got %0d want 0", pulses + busy_seen); end
      data_valid = 1'b1; sof = 1'b1; pixel_in = 8'd60; tick();
      data_valid = 1'b0; eof = 1'b1; pixel_in = 8'd0; tick();
      data_valid = 1'b1; sof = 1'b0; eof = 1'b0; pixel_in = 8'd90; tick();
      eof = 1'b1; pixel_in = 8'd75; tick();
      data_valid = 1'b0; eof = 1'b0;
      sb.push_back(model(60, 90));
      wait_coeff(n);
      e = sb.pop_front();
      checks++; if (n !== 19) begin errors++; $display("FAIL invalid_latency got %0d want 19", n); end
      checks++; if (alpha_out !== e.a || beta_out !== e.b) begin errors++; $display("FAIL invalid_coeff got %h/%h want %h/%h", alpha_out, beta_out, e.a, e.b); end
      checks++; if (frame_min !== e.mn || frame_max !== e.mx) begin errors++; $display("FAIL invalid_minmax got %0d/%0d want %0d/%0d", frame_min, frame_max, e.mn, e.mx); end
      repeat (2) tick();
   endtask
   task automatic test_abort();
      exp_t e;
      int   n, pulses = 0;
      send_frame('{8'd5, 8'd250});
      repeat (8) tick();
      rst_n = 1'b0;
      #1;
      void'(sb.pop_front());
      checks++; if (alpha_out !== 16'h0100 || beta_out !== 16'h0000) begin errors++; $display("FAIL abort_coeff got %h/%h want 0100/0000", alpha_out, beta_out); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
      repeat (2) begin tick(); if (coeff_valid) pulses++; end
      rst_n = 1'b1;
      repeat (30) begin tick(); if (coeff_valid) pulses++; end
      checks++; if (pulses !== 0) begin errors++; $display("FAIL abort_no_pulse got %0d want 0", pulses); end
      send_frame('{8'd40, 8'd120, 8'd80});
      wait_coeff(n);
      e = sb.pop_front();
      checks++; if (n !== 19) begin errors++; $display("FAIL abort_next_latency got %0d want 19", n); end
      checks++; if (alpha_out !== e.a || beta_out !== e.b) begin errors++; $display("FAIL abort_next_coeff got %h/%h want %h/%h", alpha_out, beta_out, e.a, e.b); end
      checks++; if (frame_min !== e.mn || frame_max !== e.mx) begin errors++; $display("FAIL abort_next_minmax got %0d/%0d want %0d/%0d", frame_min, frame_max, e.mn, e.mx); end
   endtask
   initial begin
      test_reset();
      test_ramp();
      test_frames();
      test_dropped();
      test_invalid();
      test_abort();
      checks++; if (sb.size() !== 0) begin errors++; $display("FAIL scoreboard_left got %0d want 0", sb.size()); end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
